trace_capture: RTL

Synthesizable trace buffer that records per-instruction snapshots of the single-cycle datapath's observation outputs (PC, opcode, two register operands, ALU result) with a cycle stamp. It replaces hand-inspection of simulation monitors with an on-chip capture that works in silicon. The buffer supports an opcode trigger, circular or fill-and-stop modes, and a valid/ready readout port. It sits beside `datapath`, tapping its observation outputs, and is read out by a host or a bench.

---
 rtl/trace_pkg.sv | 34 +++
 rtl/trace_capture_if.sv | 45 ++++
 rtl/trace_ram.sv | 41 ++++
 rtl/trace_capture.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// ----------------------------------------------------------------------------
// trace_pkg
// Shared definitions for the trace capture block: FSM state encoding, capture
// mode encoding and the width of one packed trace entry.
// No ports (package).
// ----------------------------------------------------------------------------
package trace_pkg;

  // Encoding is visible on state_o, so the values are fixed.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic MODE_CIRC = 1'b0;  // overwrite oldest entry when full
  localparam logic MODE_STOP = 1'b1;  // stop capturing once full

  // Default datapath widths.
  localparam int DEF_DATA_W = 32;
  localparam int DEF_PC_W   = 8;
  localparam int DEF_OP_W   = 6;
  localparam int DEF_CNT_W  = 16;

  // One entry holds pc, opcode, two operands, result and the cycle stamp.
  function automatic int entry_width(input int pc_w, input int op_w,
                                     input int data_w, input int cnt_w);
    return pc_w + op_w + 3 * data_w + cnt_w;
  endfunction

  localparam int ENTRY_W = entry_width(DEF_PC_W, DEF_OP_W, DEF_DATA_W, DEF_CNT_W);

endpackage

// File: rtl/trace_capture_if.sv
// ----------------------------------------------------------------------------
// trace_capture_if
// Bundles the datapath observation tap (in_*) and the valid/ready readout
// port (rd_*) of the trace buffer.
//   master : the datapath/host side - drives in_* and rd_ready
//   slave  : the trace buffer side  - consumes in_*, drives rd_*
// ----------------------------------------------------------------------------
interface trace_capture_if #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 8,
  parameter int OP_W   = 6,
  parameter int CNT_W  = 16
) ();

  // Capture tap
  logic              in_valid;
  logic [PC_W-1:0]   in_pc;
  logic [OP_W-1:0]   in_opcode;
  logic [DATA_W-1:0] in_reg_1;
  logic [DATA_W-1:0] in_reg_2;
  logic [DATA_W-1:0] in_result;

  // Readout port
  logic              rd_valid;
  logic              rd_ready;
  logic [PC_W-1:0]   rd_pc;
  logic [OP_W-1:0]   rd_opcode;
  logic [DATA_W-1:0] rd_reg_1;
  logic [DATA_W-1:0] rd_reg_2;
  logic [DATA_W-1:0] rd_result;
  logic [CNT_W-1:0]  rd_cycle;

  modport master (
    output in_valid, in_pc, in_opcode, in_reg_1, in_reg_2, in_result,
    output rd_ready,
    input  rd_valid, rd_pc, rd_opcode, rd_reg_1, rd_reg_2, rd_result, rd_cycle
  );

  modport slave (
    input  in_valid, in_pc, in_opcode, in_reg_1, in_reg_2, in_result,
    input  rd_ready,
    output rd_valid, rd_pc, rd_opcode, rd_reg_1, rd_reg_2, rd_result, rd_cycle
  );

endinterface

// File: rtl/trace_ram.sv
// ----------------------------------------------------------------------------
// trace_ram
// DEPTH x WIDTH register array holding trace entries.
//   clk     : clock, rising edge
//   clr     : synchronous clear of every entry (wins over a write)
//   we      : write enable
//   wr_addr : write address
//   wr_data : write data
//   rd_addr : read address
//   rd_data : asynchronous read of the entry at rd_addr
// ----------------------------------------------------------------------------
module trace_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // A plain register array (not block RAM) because the readout port is
  // combinational and the whole buffer must clear in one cycle.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/trace_capture.sv
// ----------------------------------------------------------------------------
// trace_capture
// On-chip trace buffer for the single-cycle datapath. Records one entry per
// retired instruction (pc, opcode, operands, result, cycle stamp), with an
// optional opcode trigger, circular or fill-and-stop capture, and a
// valid/ready readout (oldest entry first) once capture has ended.
//   clk         : clock, rising edge
//   rst_n       : synchronous active-low reset
//   bus         : capture tap + readout port (slave side)
//   arm         : pulse, IDLE -> ARMED; latches mode/trig_en/trig_opcode
//   stop        : pulse, ends ARMED (no capture) or CAPTURE (go to readout)
//   mode        : 0 circular, 1 fill-and-stop
//   trig_en     : 1 wait for opcode match, 0 start immediately
//   trig_opcode : trigger opcode
//   count       : entries held
//   state_o     : current state (IDLE/ARMED/CAPTURE/DONE)
//   overflow    : sticky, circular capture overwrote at least one entry
// ----------------------------------------------------------------------------
module trace_capture
  import trace_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PC_W   = 8,
  parameter int OP_W   = 6,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  trace_capture_if.slave         bus,
  input  logic                   arm,
  input  logic                   stop,
  input  logic                   mode,
  input  logic                   trig_en,
  input  logic [OP_W-1:0]        trig_opcode,
  output logic [$clog2(DEPTH):0] count,
  output logic [1:0]             state_o,
  output logic                   overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int EW    = entry_width(PC_W, OP_W, DATA_W, CNT_W);
  localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

  state_t             state_reg, state_next;
  logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [PTR_W:0]     count_reg, count_next;
  logic               overflow_reg, overflow_next;
  logic               rd_valid_reg, rd_valid_next;
  logic               mode_reg, mode_next;
  logic               trig_en_reg, trig_en_next;
  logic [OP_W-1:0]    trig_op_reg, trig_op_next;
  logic [CNT_W-1:0]   cyc_reg;

  logic               we;
  logic               arm_clr;
  logic               ram_clr;
  logic [EW-1:0]      wr_entry;
  logic [EW-1:0]      rd_entry;

  // --------------------------------------------------------------------------
  // Free-running cycle stamp
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cyc_reg <= '0;
    end else begin
      cyc_reg <= cyc_reg + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // State and bookkeeping registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      rd_valid_reg <= 1'b0;
      mode_reg     <= MODE_CIRC;
      trig_en_reg  <= 1'b0;
      trig_op_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
      rd_valid_reg <= rd_valid_next;
      mode_reg     <= mode_next;
      trig_en_reg  <= trig_en_next;
      trig_op_reg  <= trig_op_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state / datapath control
  // --------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    count_next    = count_reg;
    overflow_next = overflow_reg;
    mode_next     = mode_reg;
    trig_en_next  = trig_en_reg;
    trig_op_next  = trig_op_reg;
    we            = 1'b0;
    arm_clr       = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (arm) begin
          state_next    = ARMED;
          mode_next     = mode;
          trig_en_next  = trig_en;
          trig_op_next  = trig_opcode;
          arm_clr       = 1'b1;
          wr_ptr_next   = '0;
          rd_ptr_next   = '0;
          count_next    = '0;
          overflow_next = 1'b0;
        end
      end

      ARMED: begin
        // stop beats a coincident trigger match: nothing is recorded.
        if (stop) begin
          state_next = IDLE;
        end else if (!trig_en_reg) begin
          state_next = CAPTURE;
        end else if (bus.in_valid && (bus.in_opcode == trig_op_reg)) begin
          // The triggering instruction itself becomes entry 0.
          we          = 1'b1;
          wr_ptr_next = wr_ptr_reg + 1'b1;
          count_next  = count_reg + 1'b1;
          state_next  = CAPTURE;
        end
      end

      CAPTURE: begin
        if (bus.in_valid) begin
          we          = 1'b1;
          wr_ptr_next = wr_ptr_reg + 1'b1;
          if (count_reg == FULL) begin
            // Only reachable in circular mode: the oldest entry is lost,
            // so the read pointer follows the write pointer.
            rd_ptr_next   = rd_ptr_reg + 1'b1;
            overflow_next = 1'b1;
          end else begin
            count_next = count_reg + 1'b1;
          end
        end
        if (stop) begin
          state_next = DONE;
        end else if ((mode_reg == MODE_STOP) && (count_next == FULL)) begin
          state_next = DONE;
        end
      end

      DONE: begin
        if (count_reg == '0) begin
          state_next = IDLE;
        end else if (rd_valid_reg && bus.rd_ready) begin
          rd_ptr_next = rd_ptr_reg + 1'b1;
          count_next  = count_reg - 1'b1;
          if (count_reg == (PTR_W + 1)'(1)) begin
            state_next = IDLE;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // Registered so that it lines up with the pointer/count it describes.
    rd_valid_next = (state_next == DONE) && (count_next != '0);
  end

  // --------------------------------------------------------------------------
  // Entry storage
  // --------------------------------------------------------------------------
  assign ram_clr  = arm_clr | ~rst_n;
  assign wr_entry = {bus.in_pc, bus.in_opcode, bus.in_reg_1, bus.in_reg_2,
                     bus.in_result, cyc_reg};

  trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_ram (
    .clk     (clk),
    .clr     (ram_clr),
    .we      (we),
    .wr_addr (wr_ptr_reg),
    .wr_data (wr_entry),
    .rd_addr (rd_ptr_reg),
    .rd_data (rd_entry)
  );

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign {bus.rd_pc, bus.rd_opcode, bus.rd_reg_1, bus.rd_reg_2,
          bus.rd_result, bus.rd_cycle} = rd_entry;
  assign bus.rd_valid = rd_valid_reg;
  assign count        = count_reg;
  assign state_o      = state_reg;
  assign overflow     = overflow_reg;

endmodule
